// File: rtl/crc_stream.sv
// Streaming CRC engine: byte-enabled beats of up to DWIDTH bits, one full-beat
// CRC update per cycle, and a registered result strobe one cycle after s_last.
module crc_stream #(
   parameter int                DWIDTH    = 64,
   parameter int                OWIDTH    = 32,
   parameter logic [OWIDTH-1:0] POLY      = OWIDTH'(32'h04C11DB7),
   parameter logic [OWIDTH-1:0] INIT      = '1,
   parameter logic [OWIDTH-1:0] XOROUT    = '1,
   parameter bit                LSB_FIRST = 1'b1,
   parameter logic [OWIDTH-1:0] RESIDUE   = OWIDTH'(32'hDEBB20E3),
   parameter int                LWIDTH    = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                s_valid,
   input  logic [DWIDTH-1:0]   s_data,
   input  logic [DWIDTH/8-1:0] s_keep,
   input  logic                s_last,
   output logic                crc_valid,
   output logic [OWIDTH-1:0]   crc,
   output logic                crc_ok,
   output logic [LWIDTH-1:0]   frame_len,
   output logic                frame_err
);

   localparam int NB = DWIDTH / 8;

   function automatic logic [OWIDTH-1:0] reflect(input logic [OWIDTH-1:0] v);
      logic [OWIDTH-1:0] res;
      for (int i = 0; i < OWIDTH; i++) res[i] = v[OWIDTH-1-i];
      return res;
   endfunction

   localparam logic [OWIDTH-1:0] POLY_R = reflect(POLY);

   logic [OWIDTH-1:0] r_q, r_d;
   logic [LWIDTH-1:0] len_q, len_d;
   logic              err_q, err_d;
   logic              in_frame_q;
   logic              crc_valid_q;
   logic [OWIDTH-1:0] crc_q;
   logic              crc_ok_q;
   logic [LWIDTH-1:0] frame_len_q;
   logic              frame_err_q;

   logic [LWIDTH+7:0] sum_v;
   logic              gap_v;

   // NOTE: the per-byte chain below relies on blocking assignments so each byte
   // sees the register produced by the byte before it within the same cycle;
   // every variable is given a value up front so no latch is inferred.
   always_comb begin
      r_d   = in_frame_q ? r_q : INIT;
      err_d = in_frame_q ? err_q : 1'b0;
      sum_v = {8'd0, (in_frame_q ? len_q : {LWIDTH{1'b0}})};
      gap_v = 1'b0;
      for (int k = 0; k < NB; k++) begin
         if (s_keep[k]) begin
            if (gap_v) err_d = 1'b1;
            sum_v = sum_v + {{(LWIDTH+7){1'b0}}, 1'b1};
            if (LSB_FIRST) begin
               r_d[7:0] = r_d[7:0] ^ s_data[8*k +: 8];
               for (int b = 0; b < 8; b++)
                  r_d = {1'b0, r_d[OWIDTH-1:1]} ^ (r_d[0] ? POLY_R : '0);
            end else begin
               r_d[OWIDTH-1 -: 8] = r_d[OWIDTH-1 -: 8] ^ s_data[8*k +: 8];
               for (int b = 0; b < 8; b++)
                  r_d = {r_d[OWIDTH-2:0], 1'b0} ^ (r_d[OWIDTH-1] ? POLY : '0);
            end
         end else begin
            gap_v = 1'b1;
         end
      end
      // A partial beat is only legal when it closes the frame.
      if (!s_last && !(&s_keep)) err_d = 1'b1;
      len_d = (|sum_v[LWIDTH+7:LWIDTH]) ? {LWIDTH{1'b1}} : sum_v[LWIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q         <= INIT;
         len_q       <= '0;
         err_q       <= 1'b0;
         in_frame_q  <= 1'b0;
         crc_valid_q <= 1'b0;
         crc_q       <= '0;
         crc_ok_q    <= 1'b0;
         frame_len_q <= '0;
         frame_err_q <= 1'b0;
      end else begin
         crc_valid_q <= s_valid && s_last;
         if (s_valid) begin
            r_q        <= r_d;
            len_q      <= len_d;
            err_q      <= err_d;
            in_frame_q <= !s_last;
            if (s_last) begin
               crc_q       <= r_d ^ XOROUT;
               crc_ok_q    <= (r_d == RESIDUE);
               frame_len_q <= len_d;
               frame_err_q <= err_d;
            end
         end
      end
   end

   assign crc_valid = crc_valid_q;
   assign crc       = crc_q;
   assign crc_ok    = crc_ok_q;
   assign frame_len = frame_len_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_crc_stream.sv
// Scoreboard bench for crc_stream: directed frames push expected results,
// per-DUT monitors pop and compare on every crc_valid strobe.
module tb_crc_stream;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s_valid = 1'b0;
   logic        v2 = 1'b0;
   logic [63:0] s_data = '0;
   logic [7:0]  s_keep = '0;
   logic        s_last = 1'b0;

   logic        crc_valid, crc_ok, frame_err;
   logic [31:0] crc;
   logic [15:0] frame_len;
   logic        crc_valid2, crc_ok2, frame_err2;
   logic [31:0] crc2;
   logic [15:0] frame_len2;

   crc_stream dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data),
      .s_keep(s_keep), .s_last(s_last), .crc_valid(crc_valid), .crc(crc),
      .crc_ok(crc_ok), .frame_len(frame_len), .frame_err(frame_err)
   );

   crc_stream #(.LSB_FIRST(1'b0)) dut_msb (
      .clk(clk), .rst_n(rst_n), .s_valid(v2), .s_data(s_data),
      .s_keep(s_keep), .s_last(s_last), .crc_valid(crc_valid2), .crc(crc2),
      .crc_ok(crc_ok2), .frame_len(frame_len2), .frame_err(frame_err2)
   );

   typedef struct {
      logic [31:0] crc;
      logic        ok;
      logic [15:0] len;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   last_cyc = 0;
   bit   sel2 = 1'b0;
   bit   have1 = 1'b0;
   logic [31:0] hold_crc = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l);
      s_data = d;
      s_keep = k;
      s_last = l;
      if (sel2) v2 = 1'b1;
      else s_valid = 1'b1;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      v2 = 1'b0;
      s_last = 1'b0;
      last_cyc = cyc;
   endtask

   task automatic exp_res(input logic [31:0] c, input logic ok, input logic [15:0] len,
                          input logic err);
      exp_t e;
      e.crc = c; e.ok = ok; e.len = len; e.err = err; e.cyc = last_cyc;
      if (sel2) q2.push_back(e);
      else q1.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"}, 64'(crc_valid), 64'd0);
      check({tag, "_crc"},   64'(crc),       64'd0);
      check({tag, "_ok"},    64'(crc_ok),    64'd0);
      check({tag, "_len"},   64'(frame_len), 64'd0);
      check({tag, "_err"},   64'(frame_err), 64'd0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         have1 = 1'b0;
      end else if (crc_valid) begin
         if (q1.size() == 0) begin
            check("stray_crc_valid", 64'(crc_valid), 64'd0);
         end else begin
            e = q1.pop_front();
            check("crc",       64'(crc),       64'(e.crc));
            check("crc_ok",    64'(crc_ok),    64'(e.ok));
            check("frame_len", 64'(frame_len), 64'(e.len));
            check("frame_err", 64'(frame_err), 64'(e.err));
            check("latency",   64'(cyc),       64'(e.cyc));
            hold_crc = e.crc;
            have1 = 1'b1;
         end
      end else if (have1) begin
         check("hold_crc", 64'(crc), 64'(hold_crc));
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && crc_valid2) begin
         if (q2.size() == 0) begin
            check("msb_stray_crc_valid", 64'(crc_valid2), 64'd0);
         end else begin
            e = q2.pop_front();
            check("msb_crc",       64'(crc2),       64'(e.crc));
            check("msb_crc_ok",    64'(crc_ok2),    64'(e.ok));
            check("msb_frame_len", 64'(frame_len2), 64'(e.len));
            check("msb_frame_err", 64'(frame_err2), 64'(e.err));
            check("msb_latency",   64'(cyc),        64'(e.cyc));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // "12345678" and "9", little-endian byte lanes
      logic [63:0] d1;
      d1 = 64'h3837363534333231;

      @(negedge clk);
      check_zero("reset");
      idle(2);
      rst_n = 1'b1;
      idle(1);

      // CRC-32 check value, then the same frame carrying its FCS, back to back
      beat(d1, 8'hFF, 1'b0);
      beat(64'h39, 8'h01, 1'b1);
      exp_res(32'hCBF43926, 1'b0, 16'd9, 1'b0);
      beat(d1, 8'hFF, 1'b0);
      beat(64'h000000CBF4392639, 8'h1F, 1'b1);
      exp_res(32'h2144DF1C, 1'b1, 16'd13, 1'b0);
      idle(2);

      beat(64'h0, 8'h00, 1'b1);
      exp_res(32'h00000000, 1'b0, 16'd0, 1'b0);
      idle(2);

      // Partial non-last beat: "1234567" then "89"; CRC unaffected, error flagged
      beat(64'hAA37363534333231, 8'h7F, 1'b0);
      beat(64'h3938, 8'h03, 1'b1);
      exp_res(32'hCBF43926, 1'b0, 16'd9, 1'b1);
      idle(1);

      // Non-contiguous keep=05 processes "a" and "b", skipping the FF lane
      beat(64'h62FF61, 8'h05, 1'b1);
      exp_res(32'h9E83486D, 1'b0, 16'd2, 1'b1);
      idle(2);

      // Two single-beat frames in consecutive cycles
      beat(64'h61, 8'h01, 1'b1);
      exp_res(32'hE8B7BE43, 1'b0, 16'd1, 1'b0);
      beat(64'h6261, 8'h03, 1'b1);
      exp_res(32'h9E83486D, 1'b0, 16'd2, 1'b0);
      idle(3);

      // CRC-32/BZIP2 on the msb-first instance
      sel2 = 1'b1;
      beat(d1, 8'hFF, 1'b0);
      beat(64'h39, 8'h01, 1'b1);
      exp_res(32'hFC891918, 1'b0, 16'd9, 1'b0);
      sel2 = 1'b0;
      idle(3);

      // Reset in the middle of a frame discards it
      beat(d1, 8'hFF, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      check_zero("midreset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1);
      beat(d1, 8'hFF, 1'b0);
      beat(64'h39, 8'h01, 1'b1);
      exp_res(32'hCBF43926, 1'b0, 16'd9, 1'b0);

      for (int i = 0; i < 20 && (q1.size() + q2.size()) != 0; i++) @(negedge clk);
      check("queue_drain", 64'(q1.size() + q2.size()), 64'd0);
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
